// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: widths, opcodes, field helpers and FSM states.
package instruction_fetch_unit_pkg;

  localparam int ADDR_W   = 10;
  localparam int INSTR_W  = 32;
  localparam int OPC_W    = 8;
  localparam int JTGT_LSB = 16;

  localparam logic [OPC_W-1:0] OPC_NOP = 8'h00;
  localparam logic [OPC_W-1:0] OPC_STO = 8'h01;
  localparam logic [OPC_W-1:0] OPC_LED = 8'h02;
  localparam logic [OPC_W-1:0] OPC_JMP = 8'h04;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  function automatic logic [OPC_W-1:0] opcode_of(instr_t w);
    return w[INSTR_W-1 -: OPC_W];
  endfunction

  function automatic addr_t jmp_target_of(instr_t w);
    return w[JTGT_LSB +: ADDR_W];
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: PC/ROM port, execute redirect and decoder valid/ready handshake.
interface instruction_fetch_unit_if;
  import instruction_fetch_unit_pkg::*;

  logic   i_enable;
  addr_t  o_address;
  instr_t i_instruction;
  logic   i_branch_taken;
  addr_t  i_branch_target;
  instr_t o_instruction;
  addr_t  o_pc;
  logic   o_valid;
  logic   i_ready;

  modport slave (
    input  i_enable, i_instruction, i_branch_taken, i_branch_target, i_ready,
    output o_address, o_instruction, o_pc, o_valid
  );

  modport master (
    output i_enable, i_instruction, i_branch_taken, i_branch_target, i_ready,
    input  o_address, o_instruction, o_pc, o_valid
  );

endinterface

// File: rtl/instruction_fetch_unit_fetch_next_pc.sv
// Next-PC selection: redirect beats JMP, JMP beats sequential, no fetch holds.
module instruction_fetch_unit_fetch_next_pc
  import instruction_fetch_unit_pkg::*;
(
  input  addr_t i_pc,
  input  logic  i_branch_taken,
  input  addr_t i_branch_target,
  input  logic  i_fetch,
  input  logic  i_is_jmp,
  input  addr_t i_jmp_target,
  output addr_t o_next_pc
);

  always_comb begin
    o_next_pc = i_pc;
    if (i_branch_taken)
      o_next_pc = i_branch_target;
    else if (i_fetch && i_is_jmp)
      o_next_pc = i_jmp_target;
    else if (i_fetch)
      o_next_pc = i_pc + addr_t'(1);
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives ROM address, registers the ROM word and hands it to the decoder.
// JMPs are resolved here and never issued; execute redirects flush the held slot.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  instruction_fetch_unit_if.slave  bus
);

  fetch_state_e r_state;
  addr_t        r_pc;
  instr_t       r_instr;
  addr_t        r_opc;
  logic         r_valid;

  logic  w_slot_free;
  logic  w_fetch;
  logic  w_is_jmp;
  logic  w_handshake;
  addr_t w_jmp_target;
  addr_t w_next_pc;

  assign w_slot_free  = !r_valid || bus.i_ready;
  assign w_fetch      = (r_state == ST_RUN) && w_slot_free;
  assign w_handshake  = r_valid && bus.i_ready;
  assign w_is_jmp     = (opcode_of(bus.i_instruction) == OPC_JMP);
  assign w_jmp_target = jmp_target_of(bus.i_instruction);

  instruction_fetch_unit_fetch_next_pc u_next_pc (
    .i_pc            (r_pc),
    .i_branch_taken  (bus.i_branch_taken),
    .i_branch_target (bus.i_branch_target),
    .i_fetch         (w_fetch),
    .i_is_jmp        (w_is_jmp),
    .i_jmp_target    (w_jmp_target),
    .o_next_pc       (w_next_pc)
  );

  assign bus.o_address     = r_pc;
  assign bus.o_instruction = r_instr;
  assign bus.o_pc          = r_opc;
  assign bus.o_valid       = r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_HALT;
      r_pc    <= '0;
      r_instr <= '0;
      r_opc   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_HALT: if (bus.i_enable)  r_state <= ST_RUN;
        ST_RUN:  if (!bus.i_enable) r_state <= ST_HALT;
      endcase

      r_pc <= w_next_pc;

      // A redirect flushes the slot even when the decoder is stalling it.
      if (bus.i_branch_taken) begin
        r_valid <= 1'b0;
      end else if (!w_fetch) begin
        if (w_handshake)
          r_valid <= 1'b0;
      end else if (w_is_jmp) begin
        r_valid <= 1'b0;
      end else begin
        r_instr <= bus.i_instruction;
        r_opc   <= r_pc;
        r_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed scenarios plus a randomized run checked by a program-order scoreboard.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_unit_if ifc();

  instruction_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  logic [31:0] rom [0:1023];
  assign ifc.i_instruction = rom[ifc.o_address];

  int n_checks = 0;
  int n_errors = 0;
  int n_hs     = 0;
  bit sb_en    = 1'b0;

  typedef struct {
    logic [9:0]  pc;
    logic [31:0] instr;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic [9:0] m_pc = '0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endfunction

  function automatic logic model_is_jmp(logic [31:0] w);
    return (w >> 24) == 32'(OPC_JMP);
  endfunction

  function automatic logic [9:0] model_jtgt(logic [31:0] w);
    return 10'((w >> 16) & 32'h3FF);
  endfunction

  // Walk the program from m_pc: JMPs redirect silently, everything else is issued in order.
  function automatic void refill();
    for (int k = 0; k < 1100 && exp_q.size() < 4; k++) begin
      if (model_is_jmp(rom[m_pc])) begin
        m_pc = model_jtgt(rom[m_pc]);
      end else begin
        exp_q.push_back('{m_pc, rom[m_pc]});
        m_pc = m_pc + 10'd1;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (sb_en) begin
      if (rst) begin
        exp_q.delete();
        m_pc = '0;
      end else begin
        if (ifc.o_valid)
          check("jmp_never_issued", 64'(ifc.o_instruction[31:24] != OPC_JMP), 64'(1));
        if (ifc.o_valid && ifc.i_ready) begin
          refill();
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_empty: got issue pc 0x%0h expected no issue", ifc.o_pc);
          end else begin
            e = exp_q.pop_front();
            check("sb_pc",    64'(ifc.o_pc),          64'(e.pc));
            check("sb_instr", 64'(ifc.o_instruction), 64'(e.instr));
            n_hs++;
          end
        end
        if (ifc.i_branch_taken) begin
          exp_q.delete();
          m_pc = ifc.i_branch_target;
        end
        refill();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_issue(string name, logic [9:0] pc);
    check({name, "_valid"}, 64'(ifc.o_valid),       64'(1));
    check({name, "_pc"},    64'(ifc.o_pc),          64'(pc));
    check({name, "_instr"}, 64'(ifc.o_instruction), 64'(rom[pc]));
  endtask

  initial begin
    ifc.i_enable        = 1'b0;
    ifc.i_branch_taken  = 1'b0;
    ifc.i_branch_target = '0;
    ifc.i_ready         = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = {OPC_NOP, 24'(i)};
    rom[0]     = {OPC_NOP, 24'h00A0A0};
    rom[1]     = {OPC_STO, 24'h000111};
    rom[2]     = {OPC_STO, 24'h000222};
    rom[3]     = {OPC_STO, 24'h000333};
    rom[5]     = {OPC_LED, 24'h000555};
    rom[6]     = {OPC_JMP, 8'd1, 16'b0};
    rom[10'h3FF] = {OPC_STO, 24'h0003FF};

    #1 rst = 1'b1;
    #1;
    check("por_valid", 64'(ifc.o_valid),   64'(0));
    check("por_addr",  64'(ifc.o_address), 64'(0));

    // Streaming: one HALT->RUN edge, then one instruction per cycle.
    tick();
    rst = 1'b0;
    ifc.i_enable = 1'b1;
    ifc.i_ready  = 1'b1;
    tick();
    check("t2_idle_valid", 64'(ifc.o_valid),   64'(0));
    check("t2_idle_addr",  64'(ifc.o_address), 64'(0));
    tick(); expect_issue("t2_c0", 10'd0);
    tick(); expect_issue("t2_c1", 10'd1);
    tick(); expect_issue("t2_c2", 10'd2);
    check("t2_addr", 64'(ifc.o_address), 64'(3));

    // Stall holds everything, release issues the next one without loss.
    ifc.i_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      expect_issue("t3_stall", 10'd2);
      check("t3_stall_addr", 64'(ifc.o_address), 64'(3));
    end
    ifc.i_ready = 1'b1;
    tick(); expect_issue("t3_release", 10'd3);

    // Redirect to 5, LED issues, JMP at 6 leaves a bubble, then 1.
    ifc.i_branch_taken  = 1'b1;
    ifc.i_branch_target = 10'd5;
    tick();
    check("t4_flush_valid", 64'(ifc.o_valid),   64'(0));
    check("t4_flush_addr",  64'(ifc.o_address), 64'(5));
    ifc.i_branch_taken = 1'b0;
    tick(); expect_issue("t4_led", 10'd5);
    tick();
    check("t4_bubble_valid", 64'(ifc.o_valid),   64'(0));
    check("t4_bubble_addr",  64'(ifc.o_address), 64'(1));
    tick(); expect_issue("t4_target", 10'd1);

    // Redirect while stalled flushes, then 0x3FF issues and the PC wraps.
    ifc.i_ready         = 1'b0;
    ifc.i_branch_taken  = 1'b1;
    ifc.i_branch_target = 10'h3FF;
    tick();
    check("t5_flush_valid", 64'(ifc.o_valid),   64'(0));
    check("t5_flush_addr",  64'(ifc.o_address), 64'h3FF);
    ifc.i_branch_taken = 1'b0;
    ifc.i_ready        = 1'b1;
    tick(); expect_issue("t5_top", 10'h3FF);
    check("t5_wrap_addr", 64'(ifc.o_address), 64'(0));

    // Halt: held slot drains, PC freezes, fetch resumes from the frozen PC.
    ifc.i_enable = 1'b0;
    tick();
    tick();
    check("t6_drain_valid", 64'(ifc.o_valid),   64'(0));
    check("t6_frozen_addr", 64'(ifc.o_address), 64'(1));
    tick();
    check("t6_still_valid", 64'(ifc.o_valid),   64'(0));
    check("t6_still_addr",  64'(ifc.o_address), 64'(1));
    ifc.i_enable = 1'b1;
    tick();
    tick(); expect_issue("t6_resume", 10'd1);

    // Asynchronous reset mid-cycle with a held instruction.
    #2 rst = 1'b1;
    #1;
    check("t1_valid", 64'(ifc.o_valid),       64'(0));
    check("t1_addr",  64'(ifc.o_address),     64'(0));
    check("t1_pc",    64'(ifc.o_pc),          64'(0));
    check("t1_instr", 64'(ifc.o_instruction), 64'(0));

    for (int i = 0; i < 1024; i++) begin
      case ($urandom_range(0, 9))
        0:       rom[i] = {OPC_JMP, 24'($urandom)};
        1, 2:    rom[i] = {OPC_NOP, 24'($urandom)};
        3, 4, 5: rom[i] = {OPC_STO, 24'($urandom)};
        6, 7:    rom[i] = {OPC_LED, 24'($urandom)};
        default: rom[i] = {8'($urandom_range(16, 255)), 24'($urandom)};
      endcase
    end
    sb_en = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      ifc.i_ready         = ($urandom_range(0, 3) != 0);
      ifc.i_enable        = ($urandom_range(0, 15) != 0);
      ifc.i_branch_taken  = ($urandom_range(0, 19) == 0);
      ifc.i_branch_target = 10'($urandom);
      tick();
    end
    ifc.i_branch_taken = 1'b0;
    tick();
    sb_en = 1'b0;
    check("random_progress", 64'(n_hs > 500), 64'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
